// File: rtl/gray_pkg.sv
// Shared Gray-code helpers, FSM state encoding and default widths.
package gray_pkg;

  localparam int GRAY_DEF_W = 4;
  localparam int EVT_DEF_W  = 8;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    ST_PRIMING  = 1'b0,
    ST_TRACKING = 1'b1
  } gray_state_e;

  // Zero-extended upper bits do not disturb the low bits of the result,
  // so callers may pass any width up to GRAY_MAX_W and truncate.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_check.sv
// Combinational check: is g_prev -> g1 a single-bit Gray step of +/-1?
module gray_step_check #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_g1,
  input  logic [W-1:0] i_g_prev,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_prev_b,
  output logic         o_changed,
  output logic         o_legal,
  output logic         o_up
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] w_diff;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_onehot;

  assign w_diff    = i_g1 ^ i_g_prev;
  assign w_onehot  = (w_diff != '0) && ((w_diff & (w_diff - ONE)) == '0);
  // Sized arithmetic wraps modulo 2^W, covering 15->0 and 0->15.
  assign w_inc     = i_prev_b + ONE;
  assign w_dec     = i_prev_b - ONE;
  assign o_changed = |w_diff;
  assign o_up      = w_onehot && (i_b == w_inc);
  assign o_legal   = w_onehot && ((i_b == w_inc) || (i_b == w_dec));

endmodule

// File: rtl/gray_count_decoder.sv
// Two-stage Gray-count decoder with step legality, direction and +1 event count.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int COUNTER_WIDTH = GRAY_DEF_W,
  parameter int EVENT_WIDTH   = EVT_DEF_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n_in,
  input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
  input  logic                     Clear_in,
  output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
  output logic                     Valid_out,
  output logic                     Up_out,
  output logic                     Error_out,
  output logic [EVENT_WIDTH-1:0]   EventCount_out
);

  gray_state_e              r_state, w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_g1, r_g_prev, r_bin;
  logic                     r_g1_vld;
  logic                     r_valid, r_up, r_err;
  logic [EVENT_WIDTH-1:0]   r_evt;
  logic [COUNTER_WIDTH-1:0] w_b, w_prev_b;
  logic                     w_changed, w_legal, w_up;
  logic                     w_eval, w_load_prev;

  assign w_b      = COUNTER_WIDTH'(gray2bin(GRAY_MAX_W'(r_g1)));
  assign w_prev_b = COUNTER_WIDTH'(gray2bin(GRAY_MAX_W'(r_g_prev)));

  gray_step_check #(.W(COUNTER_WIDTH)) u_chk (
    .i_g1      (r_g1),
    .i_g_prev  (r_g_prev),
    .i_b       (w_b),
    .i_prev_b  (w_prev_b),
    .o_changed (w_changed),
    .o_legal   (w_legal),
    .o_up      (w_up)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n_in) begin
    if (!Rst_n_in) r_state <= ST_PRIMING;
    else           r_state <= w_state_nxt;
  end

  // Next state and stage-2 controls. Priming waits until g1 holds a real
  // sample, so the reset value of g1 is never taken as a baseline.
  always_comb begin
    w_state_nxt = r_state;
    w_eval      = 1'b0;
    w_load_prev = 1'b0;
    if (Clear_in) begin
      w_state_nxt = ST_PRIMING;
    end else begin
      case (r_state)
        ST_PRIMING: begin
          if (r_g1_vld) begin
            w_load_prev = 1'b1;
            w_state_nxt = ST_TRACKING;
          end
        end
        ST_TRACKING: begin
          w_eval      = 1'b1;
          w_load_prev = 1'b1;
        end
        default: w_state_nxt = ST_PRIMING;
      endcase
    end
  end

  // Pipeline registers, pulse outputs, sticky error and event counter.
  always_ff @(posedge Clk or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      r_g1     <= '0;
      r_g1_vld <= 1'b0;
      r_g_prev <= '0;
      r_bin    <= '0;
      r_valid  <= 1'b0;
      r_up     <= 1'b0;
      r_err    <= 1'b0;
      r_evt    <= '0;
    end else begin
      r_g1     <= GrayCount_in;
      r_g1_vld <= 1'b1;
      r_bin    <= w_b;
      if (w_load_prev) r_g_prev <= r_g1;
      r_valid  <= w_eval & w_legal;
      r_up     <= w_eval & w_legal & w_up;
      if (Clear_in) begin
        r_err <= 1'b0;
        r_evt <= '0;
      end else if (w_eval) begin
        if (w_changed && !w_legal) r_err <= 1'b1;
        if (w_legal && w_up)       r_evt <= r_evt + EVENT_WIDTH'(1);
      end
    end
  end

  assign BinaryCount_out = r_bin;
  assign Valid_out       = r_valid;
  assign Up_out          = r_up;
  assign Error_out       = r_err;
  assign EventCount_out  = r_evt;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Bench for gray_count_decoder (W=4, EW=8): vector table plus hand sequences.
module tb_gray_count_decoder;

  logic       Clk = 1'b0;
  logic       Rst_n_in;
  logic [3:0] GrayCount_in;
  logic       Clear_in;
  logic [3:0] BinaryCount_out;
  logic       Valid_out, Up_out, Error_out;
  logic [7:0] EventCount_out;

  int errors = 0;
  int checks = 0;

  gray_count_decoder #(.COUNTER_WIDTH(4), .EVENT_WIDTH(8)) dut (
    .Clk             (Clk),
    .Rst_n_in        (Rst_n_in),
    .GrayCount_in    (GrayCount_in),
    .Clear_in        (Clear_in),
    .BinaryCount_out (BinaryCount_out),
    .Valid_out       (Valid_out),
    .Up_out          (Up_out),
    .Error_out       (Error_out),
    .EventCount_out  (EventCount_out)
  );

  always #5 Clk = ~Clk;

  // Each record: Gray input, whether Clear_in is raised while this sample is
  // evaluated, and the outputs expected once this sample reaches the outputs.
  typedef struct {
    logic [3:0] g;
    logic       clr;
    logic [3:0] b;
    logic       v;
    logic       up;
    logic       err;
    logic [7:0] evt;
    int         id;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] g, input logic clr, input logic [3:0] b,
                     input logic v, input logic up, input logic err, input logic [7:0] evt);
    vec_t e;
    e.g = g; e.clr = clr; e.b = b; e.v = v; e.up = up; e.err = err; e.evt = evt;
    e.id = tbl.size();
    tbl.push_back(e);
  endtask

  task automatic chk_rec(input vec_t e);
    chk($sformatf("v%0d bin", e.id), int'(BinaryCount_out), int'(e.b));
    chk($sformatf("v%0d valid", e.id), int'(Valid_out), int'(e.v));
    if (e.v) chk($sformatf("v%0d up", e.id), int'(Up_out), int'(e.up));
    chk($sformatf("v%0d err", e.id), int'(Error_out), int'(e.err));
    chk($sformatf("v%0d evt", e.id), int'(EventCount_out), int'(e.evt));
  endtask

  // Drive one sample; outputs for a sample appear one edge after it reaches g1.
  task automatic drive(input logic [3:0] g, input logic clr, input vec_t e);
    GrayCount_in = g;
    Clear_in     = clr;
    sb.push_back(e);
    @(posedge Clk); #1;
    if (sb.size() > 1) chk_rec(sb.pop_front());
  endtask

  task automatic flush(input logic clr);
    Clear_in = clr;
    @(posedge Clk); #1;
    if (sb.size() > 0) chk_rec(sb.pop_front());
    else chk("sb underflow", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " bin"},   int'(BinaryCount_out), 0);
    chk({tag, " valid"}, int'(Valid_out), 0);
    chk({tag, " up"},    int'(Up_out), 0);
    chk({tag, " err"},   int'(Error_out), 0);
    chk({tag, " evt"},   int'(EventCount_out), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    logic [3:0] b, g;
    Rst_n_in = 1'b0; GrayCount_in = 4'b0000; Clear_in = 1'b0;

    //   gray     clr  bin v  up err evt
    add(4'b0000, 0,  0, 0, 0, 0, 0);  // baseline after reset
    add(4'b0001, 0,  1, 1, 1, 0, 1);
    add(4'b0011, 0,  2, 1, 1, 0, 2);
    add(4'b0010, 0,  3, 1, 1, 0, 3);
    add(4'b0110, 0,  4, 1, 1, 0, 4);
    add(4'b0110, 0,  4, 0, 0, 0, 4);  // no change
    add(4'b0010, 0,  3, 1, 0, 0, 4);  // down
    add(4'b0011, 0,  2, 1, 0, 0, 4);
    add(4'b0001, 0,  1, 1, 0, 0, 4);  // 2 -> 1
    add(4'b0000, 0,  0, 1, 0, 0, 4);
    add(4'b1000, 0, 15, 1, 0, 0, 4);  // 0 -> 15 wraps down
    add(4'b0000, 0,  0, 1, 1, 0, 5);  // 15 -> 0 wraps up
    add(4'b0001, 0,  1, 1, 1, 0, 6);
    add(4'b0010, 0,  3, 0, 0, 1, 6);  // two bits change
    add(4'b0011, 0,  2, 1, 0, 1, 6);  // legal after error, error sticks
    add(4'b1011, 0, 13, 0, 0, 1, 6);  // one bit but 2 -> 13
    add(4'b1001, 0, 14, 1, 1, 1, 7);
    add(4'b1000, 1, 15, 0, 0, 0, 0);  // clear wins over legal +1
    add(4'b0000, 0,  0, 0, 0, 0, 0);  // re-baseline
    add(4'b0001, 0,  1, 1, 1, 0, 1);
    add(4'b0011, 1,  2, 0, 0, 0, 0);  // clear held two cycles
    add(4'b0010, 1,  3, 0, 0, 0, 0);
    add(4'b0110, 0,  4, 0, 0, 0, 0);  // baseline
    add(4'b0111, 0,  5, 1, 1, 0, 1);

    repeat (3) @(posedge Clk);
    #1 chk_zero("reset");
    @(negedge Clk) Rst_n_in = 1'b1;

    for (int j = 0; j < tbl.size(); j++)
      drive(tbl[j].g, (j > 0) ? tbl[j-1].clr : 1'b0, tbl[j]);
    flush(tbl[tbl.size()-1].clr);

    // Long up-count from b=5, evt=1: event counter wraps past 255.
    for (int k = 1; k <= 260; k++) begin
      b = 4'((5 + k) % 16);
      g = b ^ (b >> 1);
      e.g = g; e.clr = 1'b0; e.b = b; e.v = 1'b1; e.up = 1'b1; e.err = 1'b0;
      e.evt = 8'((1 + k) % 256); e.id = 100 + k;
      drive(g, 1'b0, e);
    end
    flush(1'b0);

    // Asynchronous reset mid-count, away from any clock edge.
    GrayCount_in = 4'b1100;
    @(posedge Clk); #3;
    Rst_n_in = 1'b0;
    #1 chk_zero("async rst");
    sb.delete();
    @(negedge Clk) Rst_n_in = 1'b1;

    e.clr = 1'b0; e.up = 1'b0; e.err = 1'b0;
    e.g = 4'b0101; e.b = 4'd6; e.v = 1'b0; e.evt = 8'd0; e.id = 500;
    drive(e.g, 1'b0, e);               // baseline: no error vs reset g1
    e.g = 4'b0100; e.b = 4'd7; e.v = 1'b1; e.up = 1'b1; e.evt = 8'd1; e.id = 501;
    drive(e.g, 1'b0, e);
    e.g = 4'b1100; e.b = 4'd8; e.evt = 8'd2; e.id = 502;
    drive(e.g, 1'b0, e);
    flush(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
